// File: rtl/algorithm_multi_vc.sv
// Per-input routing stage: Y-first dimension-ordered channel selection with per-packet lock,
// a shared two-entry skid buffer toward the crossbar, and draining/counting of unroutable beats.

package algorithm_multi_vc_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int ID_WIDTH   = 4;
   localparam int DEST_WIDTH = 4;
   localparam int USER_WIDTH = 4;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
      logic [ID_WIDTH-1:0]   tid;
      logic [DEST_WIDTH-1:0] tdest;
      logic [USER_WIDTH-1:0] tuser;
      logic                  tlast;
   } axis_data_t;
endpackage

module algorithm_multi_vc
   import algorithm_multi_vc_pkg::*;
#(
   parameter int VC_NUMBER      = 2,
   parameter int VC_WIDTH       = (VC_NUMBER > 1) ? $clog2(VC_NUMBER) : 1,
   parameter int CHANNEL_NUMBER = 5 * VC_NUMBER,
   parameter int MAX_ROUTERS_X  = 4,
   parameter int MAX_ROUTERS_Y  = 4,
   // One extra bit so that targets outside the mesh can be presented and dropped.
   parameter int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X + 1),
   parameter int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y + 1),
   parameter int ROUTER_X       = 0,
   parameter int ROUTER_Y       = 0,
   parameter int ROUTING_HEADER = 0,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  axis_data_t                     in,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [VC_WIDTH-1:0]            in_vc,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0] target_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y,
   output axis_data_t                     out [CHANNEL_NUMBER],
   output logic                           out_valid [CHANNEL_NUMBER],
   input  logic                           out_ready [CHANNEL_NUMBER],
   output logic [CHANNEL_NUMBER-1:0]      busy,
   output logic [CNT_WIDTH-1:0]           drop_count
);

   localparam int CH_W = (CHANNEL_NUMBER > 1) ? $clog2(CHANNEL_NUMBER) : 1;

   localparam int DIR_LOCAL = 0;
   localparam int DIR_NORTH = 1;
   localparam int DIR_EAST  = 2;
   localparam int DIR_SOUTH = 3;
   localparam int DIR_WEST  = 4;

   typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

   state_t          state;
   logic            alive;
   logic            lock_valid;
   logic [CH_W-1:0] lock_ch;

   axis_data_t      mem [2];
   logic            wr_ptr;
   logic            rd_ptr;
   logic [1:0]      count;

   logic            is_header;
   logic            target_bad;
   logic [CH_W-1:0] route_ch;
   logic            accept;
   logic            push;
   logic            pop;
   logic            drop;
   logic            tail_pop;
   axis_data_t      head;

   assign is_header  = (in.tid == ID_WIDTH'(ROUTING_HEADER));
   assign target_bad = (int'(target_x) >= MAX_ROUTERS_X) || (int'(target_y) >= MAX_ROUTERS_Y);

   // Y is resolved before X; the VC index is clipped to the highest existing VC.
   always_comb begin
      int dir;
      int vc_clip;
      // NOTE: every variable written here gets a default first so no latch is inferred.
      dir     = DIR_LOCAL;
      vc_clip = int'(in_vc);
      if (int'(target_x) == ROUTER_X && int'(target_y) == ROUTER_Y) dir = DIR_LOCAL;
      else if (int'(target_y) < ROUTER_Y)                          dir = DIR_NORTH;
      else if (int'(target_y) > ROUTER_Y)                          dir = DIR_SOUTH;
      else if (int'(target_x) > ROUTER_X)                          dir = DIR_EAST;
      else                                                         dir = DIR_WEST;
      if (vc_clip >= VC_NUMBER) vc_clip = VC_NUMBER - 1;
      route_ch = CH_W'(dir * VC_NUMBER + vc_clip);
   end

   // A header in IDLE waits until the previous packet's tail has left, so one owner at a time.
   always_comb begin
      in_ready = 1'b0;
      if (alive) begin
         unique case (state)
            IDLE:    in_ready = is_header ? !lock_valid : 1'b1;
            FWD:     in_ready = (count != 2'd2);
            DROP:    in_ready = 1'b1;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      push = 1'b0;
      drop = 1'b0;
      unique case (state)
         IDLE: begin
            push = accept && is_header && !target_bad;
            drop = accept && !(is_header && !target_bad);
         end
         FWD:     push = accept;
         DROP:    drop = accept;
         default: ;
      endcase
   end

   assign head     = mem[rd_ptr];
   assign pop      = (count != 2'd0) && out_ready[lock_ch];
   assign tail_pop = pop && head.tlast;

   always_comb begin
      for (int i = 0; i < CHANNEL_NUMBER; i++) begin
         out_valid[i] = (count != 2'd0) && (lock_ch == CH_W'(i));
         out[i]       = out_valid[i] ? head : '0;
         busy[i]      = lock_valid && (lock_ch == CH_W'(i));
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         alive      <= 1'b0;
         lock_valid <= 1'b0;
         lock_ch    <= '0;
         drop_count <= '0;
      end else begin
         alive <= 1'b1;
         if (tail_pop) lock_valid <= 1'b0;
         if (drop && drop_count != '1) drop_count <= drop_count + 1'b1;
         unique case (state)
            IDLE: begin
               if (accept && is_header) begin
                  if (target_bad) begin
                     if (!in.tlast) state <= DROP;
                  end else begin
                     lock_ch    <= route_ch;
                     lock_valid <= 1'b1;
                     if (!in.tlast) state <= FWD;
                  end
               end
            end
            FWD:     if (accept && in.tlast) state <= IDLE;
            DROP:    if (accept && in.tlast) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: buffer storage carries no reset; an empty count masks its contents from the outputs.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_algorithm_multi_vc.sv
// Self-checking bench for algorithm_multi_vc at router (1,1), two VCs, 4-bit drop counter.
// Expected beats go into a scoreboard queue when driven and are popped when a channel handshakes.

module tb_algorithm_multi_vc;
   import algorithm_multi_vc_pkg::*;

   localparam int CHN  = 10;
   localparam int CNTW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   axis_data_t        in_beat;
   logic              in_valid;
   logic              in_ready;
   logic [0:0]        in_vc;
   logic [2:0]        target_x;
   logic [2:0]        target_y;
   axis_data_t        out_d [CHN];
   logic              out_valid [CHN];
   logic              out_ready [CHN];
   logic [CHN-1:0]    busy;
   logic [CNTW-1:0]   drop_count;
   logic [CHN-1:0]    ov;

   algorithm_multi_vc #(
      .VC_NUMBER (2),
      .ROUTER_X  (1),
      .ROUTER_Y  (1),
      .CNT_WIDTH (CNTW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in_beat),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_vc      (in_vc),
      .target_x   (target_x),
      .target_y   (target_y),
      .out        (out_d),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .drop_count (drop_count)
   );

   typedef struct {
      int         ch;
      axis_data_t data;
   } sb_t;

   typedef struct {
      logic [2:0] tx;
      logic [2:0] ty;
      logic [0:0] vc;
      int         exp_ch;
   } vec_t;

   sb_t sb_q[$];
   int  n_cmp = 0;
   int  n_err = 0;
   int  exp_drops = 0;

   always_comb begin
      for (int i = 0; i < CHN; i++) ov[i] = out_valid[i];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic axis_data_t mk(input logic [3:0] tid, input logic last);
      axis_data_t b;
      b.tdata = $urandom;
      b.tid   = tid;
      b.tdest = 4'($urandom);
      b.tuser = 4'($urandom);
      b.tlast = last;
      return b;
   endfunction

   // Presents one beat and waits (bounded) for the handshake; exp_ch < 0 marks a dropped beat.
   task automatic send(input axis_data_t b, input logic [0:0] vc, input logic [2:0] tx,
                       input logic [2:0] ty, input int exp_ch, output int waited);
      sb_t e;
      in_beat  = b;
      in_vc    = vc;
      target_x = tx;
      target_y = ty;
      in_valid = 1'b1;
      waited   = 0;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++;
         n_err++;
         $display("FAIL send_timeout: in_ready stuck low, expected a handshake (t=%0t)", $time);
      end else if (exp_ch >= 0) begin
         e.ch   = exp_ch;
         e.data = b;
         sb_q.push_back(e);
      end else if (exp_drops < (1 << CNTW) - 1) begin
         exp_drops++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((sb_q.size() != 0 || busy != '0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check(name, 64'((sb_q.size() == 0) && (busy == '0)), 64'd1);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: single valid channel, idle channels zero, popped beats match the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         check("one_valid_max", 64'($countones(ov) <= 1), 64'd1);
         for (int i = 0; i < CHN; i++) begin
            if (!out_valid[i]) begin
               if (out_d[i] !== '0) check("idle_out_zero", 64'(out_d[i]), 64'd0);
            end else if (out_ready[i]) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL sb_unexpected: beat on channel %0d, expected none", i);
               end else begin
                  sb_t e;
                  e = sb_q.pop_front();
                  check("sb_ch", 64'(i), 64'(e.ch));
                  check("sb_data", 64'(out_d[i]), 64'(e.data));
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       vecs [10];
      axis_data_t hdr;
      int         w;
      time        t0;

      vecs[0] = '{3'd1, 3'd1, 1'b0, 0};
      vecs[1] = '{3'd3, 3'd2, 1'b0, 6};
      vecs[2] = '{3'd1, 3'd0, 1'b1, 3};
      vecs[3] = '{3'd2, 3'd1, 1'b1, 5};
      vecs[4] = '{3'd0, 3'd1, 1'b0, 8};
      vecs[5] = '{3'd0, 3'd0, 1'b1, 3};
      vecs[6] = '{3'd1, 3'd1, 1'b1, 1};
      vecs[7] = '{3'd0, 3'd3, 1'b0, 6};
      vecs[8] = '{3'd3, 3'd1, 1'b1, 5};
      vecs[9] = '{3'd0, 3'd1, 1'b1, 9};

      in_beat  = '0;
      in_valid = 1'b0;
      in_vc    = '0;
      target_x = '0;
      target_y = '0;
      for (int i = 0; i < CHN; i++) out_ready[i] = 1'b1;

      // Reset values
      #12;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
      check("rst_valid", 64'(ov), 64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("post_rst_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;

      // North, vc1 -> channel 3, one-cycle latency, busy until tail pops, full throughput
      send(mk(4'd0, 1'b0), 1'b1, 3'd1, 3'd0, 3, w);
      @(negedge clk);
      check("t1_latency", 64'(out_valid[3]), 64'd1);
      check("t1_busy", 64'(busy), 64'b0000001000);
      @(posedge clk);
      #1;
      t0 = $time;
      send(mk(4'd1, 1'b0), 1'b0, 3'd0, 3'd0, 3, w);
      send(mk(4'd2, 1'b0), 1'b0, 3'd0, 3'd0, 3, w);
      send(mk(4'd0, 1'b1), 1'b0, 3'd0, 3'd0, 3, w);
      check("t1_throughput", 64'($time - t0), 64'd30);
      @(negedge clk);
      check("t1_busy_tail", 64'(busy), 64'b0000001000);
      @(posedge clk);
      @(negedge clk);
      check("t1_busy_clear", 64'(busy), 64'd0);
      drain("t1_drain");

      // Routing table: single-beat packets, each header waits for the previous lock to clear
      for (int i = 0; i < 10; i++)
         send(mk(4'd0, 1'b1), vecs[i].vc, vecs[i].tx, vecs[i].ty, vecs[i].exp_ch, w);
      drain("t2_drain");

      // Back-pressure on channel 2: two beats buffered, then in_ready low, order kept
      out_ready[2] = 1'b0;
      hdr = mk(4'd0, 1'b0);
      send(hdr, 1'b0, 3'd1, 3'd0, 2, w);
      send(mk(4'd3, 1'b0), 1'b0, 3'd0, 3'd0, 2, w);
      fork
         send(mk(4'd4, 1'b0), 1'b0, 3'd0, 3'd0, 2, w);
         begin
            repeat (4) @(negedge clk);
            check("t3_full_ready", 64'(in_ready), 64'd0);
            check("t3_hold_valid", 64'(ov), 64'b0000000100);
            check("t3_hold_data", 64'(out_d[2]), 64'(hdr));
            @(posedge clk);
            #1 out_ready[2] = 1'b1;
         end
      join
      check("t3_stalled", 64'(w >= 4), 64'd1);
      send(mk(4'd5, 1'b1), 1'b0, 3'd0, 3'd0, 2, w);
      drain("t3_drain");

      // Out-of-mesh target: whole packet drained and counted, then a normal packet
      send(mk(4'd0, 1'b0), 1'b0, 3'd5, 3'd0, -1, w);
      check("t4_no_stall_hdr", 64'(w), 64'd0);
      send(mk(4'd1, 1'b0), 1'b0, 3'd0, 3'd0, -1, w);
      send(mk(4'd0, 1'b1), 1'b0, 3'd0, 3'd0, -1, w);
      check("t4_no_stall_tail", 64'(w), 64'd0);
      check("t4_drop_count", 64'(drop_count), 64'(exp_drops));
      send(mk(4'd0, 1'b0), 1'b0, 3'd2, 3'd1, 4, w);
      send(mk(4'd1, 1'b1), 1'b0, 3'd0, 3'd0, 4, w);
      drain("t4_drain");

      // Orphan beat, then saturation of the drop counter
      send(mk(4'd7, 1'b0), 1'b0, 3'd0, 3'd0, -1, w);
      check("t5_orphan", 64'(drop_count), 64'(exp_drops));
      for (int i = 0; i < 20; i++) send(mk(4'd7, 1'b0), 1'b0, 3'd0, 3'd0, -1, w);
      check("t5_saturate", 64'(drop_count), 64'(exp_drops));

      // Reset mid-packet with beats still buffered
      out_ready[3] = 1'b0;
      send(mk(4'd0, 1'b0), 1'b1, 3'd1, 3'd0, 3, w);
      send(mk(4'd1, 1'b0), 1'b0, 3'd0, 3'd0, 3, w);
      rst_n = 1'b0;
      sb_q.delete();
      exp_drops = 0;
      #2;
      check("t6_rst_ready", 64'(in_ready), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_drop", 64'(drop_count), 64'd0);
      check("t6_rst_valid", 64'(ov), 64'd0);
      check("t6_rst_out", 64'(out_d[3]), 64'd0);
      out_ready[3] = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      send(mk(4'd0, 1'b1), 1'b1, 3'd0, 3'd1, 9, w);
      drain("t6_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
